// File: rtl/ikaopll_pkg.sv
// Shared widths, limits and helpers for the IKAOPLL output mixer.
package ikaopll_pkg;

    localparam int OP_W    = 9;
    localparam int ACC_W   = 14;
    localparam int OUT_W   = 12;
    localparam int OUT_MAX = 2047;
    localparam int OUT_MIN = -2048;

    typedef enum logic {
        ST_UNPRIMED = 1'b0,
        ST_PRIMED   = 1'b1
    } prime_e;

    typedef struct packed {
        logic cyc;
        logic ro;
        logic mo;
    } ctrl_t;

    // Frame sum to output width: clamp when saturating, else keep the low bits.
    function automatic logic [OUT_W-1:0] acc_to_out(input logic signed [ACC_W-1:0] acc,
                                                    input logic sat_en);
        logic [OUT_W-1:0] r;
        if (sat_en && (int'(acc) > OUT_MAX)) begin
            r = OUT_W'(OUT_MAX);
        end else if (sat_en && (int'(acc) < OUT_MIN)) begin
            r = OUT_W'(OUT_MIN);
        end else begin
            r = acc[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/ikaopll_cen_sr.sv
// Clock-enable gated shift register with asynchronous active-low clear.
module ikaopll_cen_sr #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_EMUCLK,
    input  logic             i_IC_n,
    input  logic             i_CEN_n,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_Q
);

    logic [DEPTH*WIDTH-1:0] r_sr;

    if (DEPTH == 1) begin : g_one
        always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
            if (!i_IC_n) begin
                r_sr <= '0;
            end else if (!i_CEN_n) begin
                r_sr <= i_D;
            end
        end
    end else begin : g_many
        always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
            if (!i_IC_n) begin
                r_sr <= '0;
            end else if (!i_CEN_n) begin
                r_sr <= {r_sr[(DEPTH-1)*WIDTH-1:0], i_D};
            end
        end
    end

    assign o_Q = r_sr[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/ikaopll_mixacc.sv
// Per-frame melody/rhythm accumulator: sums gated operator samples between
// CYCLE_00 markers and publishes the (optionally saturated) frame totals.
module ikaopll_mixacc
    import ikaopll_pkg::*;
#(
    parameter int unsigned CTRL_DLY = 1,
    parameter bit          SAT_EN   = 1'b1
) (
    input  logic             i_EMUCLK,
    input  logic             i_IC_n,
    input  logic             i_phi1_NCEN_n,
    input  logic             i_CYCLE_00,
    input  logic             i_MO_CTRL,
    input  logic             i_RO_CTRL,
    input  logic [OP_W-1:0]  i_OP_VALUE,
    output logic [OUT_W-1:0] o_MO,
    output logic [OUT_W-1:0] o_RO,
    output logic             o_SAMPLE_VALID
);

    logic                    w_tick;
    ctrl_t                   w_ctrl_in;
    ctrl_t                   w_ctrl;
    logic [OP_W-1:0]         r_d1;
    logic signed [ACC_W-1:0] w_d1_ext;
    logic signed [ACC_W-1:0] w_add_m;
    logic signed [ACC_W-1:0] w_add_r;
    logic signed [ACC_W-1:0] r_acc_m;
    logic signed [ACC_W-1:0] r_acc_r;
    prime_e                  r_prime;
    prime_e                  w_prime_nxt;
    logic                    w_dump;
    logic [OUT_W-1:0]        r_mo;
    logic [OUT_W-1:0]        r_ro;
    logic                    r_valid;

    assign w_tick    = ~i_phi1_NCEN_n;
    assign w_ctrl_in = ctrl_t'({i_CYCLE_00, i_RO_CTRL, i_MO_CTRL});

    // One extra stage so control lines up with the registered sample in r_d1.
    ikaopll_cen_sr #(
        .DEPTH (CTRL_DLY + 1),
        .WIDTH (3)
    ) u_ctrl_sr (
        .i_EMUCLK (i_EMUCLK),
        .i_IC_n   (i_IC_n),
        .i_CEN_n  (i_phi1_NCEN_n),
        .i_D      (w_ctrl_in),
        .o_Q      (w_ctrl)
    );

    assign w_d1_ext = {{(ACC_W-OP_W){r_d1[OP_W-1]}}, r_d1};
    assign w_dump   = w_tick & w_ctrl.cyc;

    always_comb begin
        w_add_m     = '0;
        w_add_r     = '0;
        w_prime_nxt = r_prime;
        if (w_ctrl.mo) begin
            w_add_m = w_d1_ext;
        end
        if (w_ctrl.ro) begin
            w_add_r = w_d1_ext;
        end
        if (w_dump) begin
            w_prime_nxt = ST_PRIMED;
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            r_prime <= ST_UNPRIMED;
        end else begin
            r_prime <= w_prime_nxt;
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            r_d1    <= '0;
            r_acc_m <= '0;
            r_acc_r <= '0;
            r_mo    <= '0;
            r_ro    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_tick) begin
                r_d1 <= i_OP_VALUE;
                // The boundary slot opens the new frame, so it seeds the accumulators.
                if (w_ctrl.cyc) begin
                    r_acc_m <= w_add_m;
                    r_acc_r <= w_add_r;
                    if (r_prime == ST_PRIMED) begin
                        r_mo    <= acc_to_out(r_acc_m, SAT_EN);
                        r_ro    <= acc_to_out(r_acc_r, SAT_EN);
                        r_valid <= 1'b1;
                    end
                end else begin
                    r_acc_m <= r_acc_m + w_add_m;
                    r_acc_r <= r_acc_r + w_add_r;
                end
            end
        end
    end

    assign o_MO           = r_mo;
    assign o_RO           = r_ro;
    assign o_SAMPLE_VALID = r_valid;

endmodule

// File: tb/tb_ikaopll_mixacc.sv
// Directed bench for ikaopll_mixacc: four instances (delay/saturation variants)
// checked every cycle against a slot-level frame-sum model plus literal pins.
module tb_ikaopll_mixacc;

    localparam int NI   = 4;
    localparam int MAXS = 512;

    logic clk = 1'b0;
    logic ic_n;
    logic ncen;
    logic [8:0] opv;
    logic mo_c [NI];
    logic ro_c [NI];
    logic cy_c [NI];
    logic signed [11:0] o_mo [NI];
    logic signed [11:0] o_ro [NI];
    logic o_v [NI];

    always #5 clk = ~clk;

    ikaopll_mixacc #(.CTRL_DLY(1), .SAT_EN(1'b1)) u_d1s (
        .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phi1_NCEN_n(ncen), .i_CYCLE_00(cy_c[0]),
        .i_MO_CTRL(mo_c[0]), .i_RO_CTRL(ro_c[0]), .i_OP_VALUE(opv),
        .o_MO(o_mo[0]), .o_RO(o_ro[0]), .o_SAMPLE_VALID(o_v[0]));
    ikaopll_mixacc #(.CTRL_DLY(1), .SAT_EN(1'b0)) u_d1w (
        .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phi1_NCEN_n(ncen), .i_CYCLE_00(cy_c[1]),
        .i_MO_CTRL(mo_c[1]), .i_RO_CTRL(ro_c[1]), .i_OP_VALUE(opv),
        .o_MO(o_mo[1]), .o_RO(o_ro[1]), .o_SAMPLE_VALID(o_v[1]));
    ikaopll_mixacc #(.CTRL_DLY(0), .SAT_EN(1'b1)) u_d0s (
        .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phi1_NCEN_n(ncen), .i_CYCLE_00(cy_c[2]),
        .i_MO_CTRL(mo_c[2]), .i_RO_CTRL(ro_c[2]), .i_OP_VALUE(opv),
        .o_MO(o_mo[2]), .o_RO(o_ro[2]), .o_SAMPLE_VALID(o_v[2]));
    ikaopll_mixacc #(.CTRL_DLY(3), .SAT_EN(1'b1)) u_d3s (
        .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phi1_NCEN_n(ncen), .i_CYCLE_00(cy_c[3]),
        .i_MO_CTRL(mo_c[3]), .i_RO_CTRL(ro_c[3]), .i_OP_VALUE(opv),
        .o_MO(o_mo[3]), .o_RO(o_ro[3]), .o_SAMPLE_VALID(o_v[3]));

    function automatic int dly_of(input int i);
        case (i)
            2:       return 0;
            3:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic bit sat_of(input int i);
        return (i != 1);
    endfunction

    // Frame total as it must appear on a 12-bit output.
    function automatic int shape(input int s, input bit sat);
        int w;
        if (sat) begin
            if (s > 2047)  return 2047;
            if (s < -2048) return -2048;
            return s;
        end
        w = ((s % 4096) + 4096) % 4096;
        return (w >= 2048) ? (w - 4096) : w;
    endfunction

    // Stimulus program, one entry per slot (controls already aligned to data).
    int s_val [MAXS];
    bit s_mo  [MAXS];
    bit s_ro  [MAXS];
    bit s_cyc [MAXS];
    int s_stall [MAXS];
    int s_rst [MAXS];
    bit p_en  [MAXS];
    int p_mo  [MAXS];
    int p_ro  [MAXS];
    int p_wmo [MAXS];
    int p_wro [MAXS];
    int nslots = 0;

    task automatic add_frame(input int len, input int val, input int mf, input int ml,
                             input int rf, input int rl, output int start);
        start = nslots;
        for (int j = 0; j < len; j++) begin
            s_val[nslots] = val;
            s_mo[nslots]  = (j >= mf) && (j <= ml);
            s_ro[nslots]  = (j >= rf) && (j <= rl);
            s_cyc[nslots] = (j == 0);
            nslots++;
        end
    endtask

    task automatic add_idle(input int n);
        for (int j = 0; j < n; j++) begin
            s_val[nslots] = 0;
            s_mo[nslots]  = 1'b0;
            s_ro[nslots]  = 1'b0;
            s_cyc[nslots] = 1'b0;
            nslots++;
        end
    endtask

    // Outputs after boundary slot b has been processed are visible while slot b+2 is driven.
    task automatic pin(input int b, input int m, input int r, input int wm, input int wr);
        p_en[b+2]  = 1'b1;
        p_mo[b+2]  = m;
        p_ro[b+2]  = r;
        p_wmo[b+2] = wm;
        p_wro[b+2] = wr;
    endtask

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", nm, i, act, exp, $time);
        end
    endtask

    // Reference model: frame sums over slots, dumped one slot after the boundary.
    int cur = -1;
    int m_inflight = -1;
    int m_sm = 0;
    int m_sr = 0;
    bit m_primed = 1'b0;
    int gm;
    int gr;
    int e_mo [NI];
    int e_ro [NI];
    bit e_v  [NI];

    always @(posedge clk or negedge ic_n) begin
        for (int i = 0; i < NI; i++) e_v[i] = 1'b0;
        if (!ic_n) begin
            m_sm = 0;
            m_sr = 0;
            m_primed = 1'b0;
            m_inflight = -1;
            for (int i = 0; i < NI; i++) begin
                e_mo[i] = 0;
                e_ro[i] = 0;
            end
        end else if (!ncen) begin
            if (m_inflight >= 0) begin
                gm = s_mo[m_inflight] ? s_val[m_inflight] : 0;
                gr = s_ro[m_inflight] ? s_val[m_inflight] : 0;
                if (s_cyc[m_inflight]) begin
                    if (m_primed) begin
                        for (int i = 0; i < NI; i++) begin
                            e_mo[i] = shape(m_sm, sat_of(i));
                            e_ro[i] = shape(m_sr, sat_of(i));
                            e_v[i]  = 1'b1;
                        end
                    end
                    m_primed = 1'b1;
                    m_sm = gm;
                    m_sr = gr;
                end else begin
                    m_sm += gm;
                    m_sr += gr;
                end
            end
            m_inflight = cur;
        end
    end

    bit run = 1'b0;
    int n_pulse [NI];

    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < NI; i++) begin
                chk("o_MO", i, int'(o_mo[i]), e_mo[i]);
                chk("o_RO", i, int'(o_ro[i]), e_ro[i]);
                chk("o_SAMPLE_VALID", i, int'(o_v[i]), int'(e_v[i]));
                if (o_v[i]) n_pulse[i]++;
            end
        end
    end

    task automatic drive(input int k);
        opv  = 9'(s_val[k]);
        cur  = k;
        ncen = 1'b0;
        for (int i = 0; i < NI; i++) begin
            mo_c[i] = s_mo[k + dly_of(i)];
            ro_c[i] = s_ro[k + dly_of(i)];
            cy_c[i] = s_cyc[k + dly_of(i)];
        end
    endtask

    initial begin
        int fa1, fa2, fa3, fb, fc, fd1, fd2, fe, ff, fg, fh, fi, fj, fk;
        ic_n = 1'b0;
        ncen = 1'b1;
        opv  = '0;
        for (int i = 0; i < NI; i++) begin
            mo_c[i] = 1'b0; ro_c[i] = 1'b0; cy_c[i] = 1'b0; n_pulse[i] = 0;
        end

        add_idle(4);
        add_frame(18, 10, 0, 8, 1, 0, fa1);
        add_frame(18, 10, 0, 8, 1, 0, fa2);
        add_frame(18, 10, 0, 8, 1, 0, fa3);
        add_frame(18, 255, 0, 17, 0, 17, fb);
        add_frame(18, -256, 0, 17, 0, 17, fc);
        add_frame(18, 7, 0, 0, 1, 0, fd1);
        add_frame(18, 0, 1, 0, 1, 0, fd2);
        add_frame(18, -3, 1, 0, 3, 4, fe);
        add_frame(18, 10, 0, 17, 1, 0, ff);
        add_frame(18, 10, 0, 17, 1, 0, fg);
        add_frame(18, 4, 0, 4, 1, 0, fh);
        add_frame(5, 3, 0, 4, 1, 0, fi);
        add_frame(18, 0, 1, 0, 1, 0, fj);
        add_frame(1, 0, 1, 0, 1, 0, fk);
        add_idle(8);
        s_stall[ff+9] = 50;
        s_rst[fg+9]   = 3;

        pin(fa1, 0, 0, 0, 0);
        pin(fa2, 90, 0, 90, 0);
        pin(fa3, 90, 0, 90, 0);
        pin(fc, 2047, 2047, 494, 494);
        pin(fd1, -2048, -2048, -512, -512);
        pin(fd2, 7, 0, 7, 0);
        pin(ff, 0, -6, 0, -6);
        pin(fg, 180, 0, 180, 0);
        pin(fh, 0, 0, 0, 0);
        pin(fi, 20, 0, 20, 0);
        pin(fj, 15, 0, 15, 0);

        repeat (3) @(posedge clk);
        #1 ic_n = 1'b1;
        ncen = 1'b0;
        run  = 1'b1;

        for (int k = 0; k < nslots; k++) begin
            @(posedge clk);
            #1;
            drive(k);
            if (p_en[k]) begin
                for (int i = 0; i < NI; i++) begin
                    chk("pin_MO", i, int'(o_mo[i]), (i == 1) ? p_wmo[k] : p_mo[k]);
                    chk("pin_RO", i, int'(o_ro[i]), (i == 1) ? p_wro[k] : p_ro[k]);
                end
                chk("model_pin_MO", 0, e_mo[0], p_mo[k]);
                chk("model_pin_wrap_MO", 1, e_mo[1], p_wmo[k]);
            end
            if (s_stall[k] > 0) begin
                ncen = 1'b1;
                repeat (s_stall[k]) @(posedge clk);
                #1 ncen = 1'b0;
            end
            if (s_rst[k] > 0) begin
                ic_n = 1'b0;
                #1;
                for (int i = 0; i < NI; i++) begin
                    chk("rst_MO", i, int'(o_mo[i]), 0);
                    chk("rst_RO", i, int'(o_ro[i]), 0);
                    chk("rst_VALID", i, int'(o_v[i]), 0);
                end
                repeat (s_rst[k]) @(posedge clk);
                #1 ic_n = 1'b1;
            end
        end

        repeat (4) @(posedge clk);
        #1 run = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk("pulse_count", i, n_pulse[i], 12);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
